// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller: Gray read pointer, synchronized write pointer, empty/almost-empty/level/underflow.
// Pointer and flags update on the read edge; rinc is dropped (and flagged as underflow) while empty.
module fifo_read_ctrl #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rinc,
  input  logic              underflow_clr,
  input  logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  output logic              rempty,
  output logic              raempty,
  output logic [ADDR_W:0]   rlevel,
  output logic              runderflow
);

  localparam logic [ADDR_W:0] AE_T = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] rgray_next;
  logic [ADDR_W:0] wq;
  logic [ADDR_W:0] wq_bin;
  logic [ADDR_W:0] lvl_next;
  logic [ADDR_W:0] wsync [SYNC_STAGES];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) wsync[i] <= '0;
    end else begin
      wsync[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) wsync[i] <= wsync[i-1];
    end
  end

  assign wq = wsync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    wq_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) wq_bin[i] = ^(wq >> i);
  end

  assign ren        = rinc & ~rempty;
  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, ren};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign lvl_next   = wq_bin - rbin_next;
  assign rlevel     = wq_bin - rbin;
  assign raddr      = rbin[ADDR_W-1:0];

  // Flags are judged against the post-read pointer so the last read raises empty on its own edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      raempty    <= 1'b1;
      runderflow <= 1'b0;
    end else begin
      rbin    <= rbin_next;
      rptr    <= rgray_next;
      rempty  <= (rgray_next == wq);
      raempty <= (lvl_next <= AE_T);
      if (rinc && rempty)
        runderflow <= 1'b1;
      else if (underflow_clr)
        runderflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl at ADDR_W=3, SYNC_STAGES=2, AE_THRESH=2.
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b1;
  logic       rinc = 1'b0;
  logic       underflow_clr = 1'b0;
  logic [3:0] wptr_gray = 4'b0000;
  logic [3:0] rptr;
  logic [2:0] raddr;
  logic       ren;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       runderflow;

  int total = 0;
  int bad = 0;
  int rdn = 0;

  fifo_read_ctrl #(.ADDR_W(3), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .underflow_clr(underflow_clr),
    .wptr_gray(wptr_gray), .rptr(rptr), .raddr(raddr), .ren(ren),
    .rempty(rempty), .raempty(raempty), .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rempty"}, 32'(rempty), 32'd1);
    chk({tag, "_raempty"}, 32'(raempty), 32'd1);
    chk({tag, "_rptr"}, 32'(rptr), 32'd0);
    chk({tag, "_raddr"}, 32'(raddr), 32'd0);
    chk({tag, "_rlevel"}, 32'(rlevel), 32'd0);
    chk({tag, "_runderflow"}, 32'(runderflow), 32'd0);
    chk({tag, "_ren"}, 32'(ren), 32'd0);
  endtask

  initial begin
    // Reset pulse between edges
    #1 rrst_n = 1'b0;
    rinc = 1'b1;
    #1 chk_reset("rst");
    rinc = 1'b0;
    #1 rrst_n = 1'b1;
    tick();

    // Write arrival: three entries
    wptr_gray = 4'b0010;
    tick();
    chk("arr_e1_rlevel", 32'(rlevel), 32'd0);
    tick();
    chk("arr_e2_rlevel", 32'(rlevel), 32'd3);
    chk("arr_e2_rempty", 32'(rempty), 32'd1);
    tick();
    chk("arr_e3_rempty", 32'(rempty), 32'd0);
    chk("arr_e3_raempty", 32'(raempty), 32'd0);

    // Drain
    rinc = 1'b1;
    #1;
    chk("drn0_ren", 32'(ren), 32'd1);
    chk("drn0_raddr", 32'(raddr), 32'd0);
    tick();
    chk("drn1_ren", 32'(ren), 32'd1);
    chk("drn1_raddr", 32'(raddr), 32'd1);
    chk("drn1_rptr", 32'(rptr), 32'b0001);
    chk("drn1_raempty", 32'(raempty), 32'd1);
    chk("drn1_rempty", 32'(rempty), 32'd0);
    chk("drn1_rlevel", 32'(rlevel), 32'd2);
    tick();
    chk("drn2_ren", 32'(ren), 32'd1);
    chk("drn2_raddr", 32'(raddr), 32'd2);
    chk("drn2_rptr", 32'(rptr), 32'b0011);
    chk("drn2_rlevel", 32'(rlevel), 32'd1);
    tick();
    chk("drn3_rptr", 32'(rptr), 32'b0010);
    chk("drn3_rempty", 32'(rempty), 32'd1);
    chk("drn3_rlevel", 32'(rlevel), 32'd0);
    chk("drn3_ren", 32'(ren), 32'd0);
    chk("drn3_runderflow", 32'(runderflow), 32'd0);

    // Underflow: rinc still high while empty
    tick();
    chk("uf_set", 32'(runderflow), 32'd1);
    chk("uf_rptr_hold", 32'(rptr), 32'b0010);
    chk("uf_raddr_hold", 32'(raddr), 32'd3);
    rinc = 1'b0;
    underflow_clr = 1'b1;
    tick();
    chk("uf_clr", 32'(runderflow), 32'd0);
    rinc = 1'b1;
    tick();
    chk("uf_set_wins", 32'(runderflow), 32'd1);
    rinc = 1'b0;
    tick();
    chk("uf_clr2", 32'(runderflow), 32'd0);
    underflow_clr = 1'b0;

    // Restart for the wrap test
    rrst_n = 1'b0;
    wptr_gray = 4'b0000;
    #1 rrst_n = 1'b1;
    tick();

    // Wrap: 16 writes, reads only while not empty
    rdn = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) wptr_gray = g(4'(c + 1));
      rinc = ~rempty;
      #1;
      if (ren) begin
        chk("wrap_raddr", 32'(raddr), 32'(rdn % 8));
        rdn++;
      end
      chk("wrap_lvl_le8", 32'(rlevel <= 4'd8), 32'd1);
      tick();
    end
    rinc = 1'b0;
    #1;
    chk("wrap_reads", 32'(rdn), 32'd16);
    chk("wrap_rptr", 32'(rptr), 32'b0000);
    chk("wrap_rempty", 32'(rempty), 32'd1);
    chk("wrap_rlevel", 32'(rlevel), 32'd0);
    chk("wrap_runderflow", 32'(runderflow), 32'd0);

    // Mid-operation reset with five entries pending
    wptr_gray = g(4'd5);
    tick();
    tick();
    tick();
    chk("mid_rlevel", 32'(rlevel), 32'd5);
    chk("mid_rempty", 32'(rempty), 32'd0);
    rrst_n = 1'b0;
    rinc = 1'b1;
    #1 chk_reset("midrst");
    tick();
    chk("midrst_hold_ren", 32'(ren), 32'd0);
    chk("midrst_hold_rlevel", 32'(rlevel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
